id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Decode stage plus ID/EX pipeline register of the 5-stage MIPS pipeline. It consumes the IF/ID instruction and PC+4 and holds the 32x32 register file. It resolves branches and jumps in ID, driving pcSrc, the target and the IF load enables. It detects load-use and branch-operand hazards and registers the control and data bundle for EX.

Parameters:
RF_DEPTH, 32, number of architectural registers; $0 hardwired to zero
RESET_PC, 32'h0000_0000, ex_pc value after reset

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
instr_ifid  in  32  instruction from IF/ID register
pc_ifid  in  32  PC+4 from IF/ID register
wb_reg_write  in  1  writeback enable
wb_dest  in  5  writeback register index
wb_data  in  32  writeback data
mem_reg_write  in  1  MEM-stage instruction writes a register
mem_mem_read  in  1  MEM-stage instruction is a load
mem_dest  in  5  MEM-stage destination index
mem_alu_result  in  32  MEM-stage ALU result
ld_pc  out  1  PC / IF-ID pc load enable; 0 = stall
ld_reg_instrIFID  out  1  IF/ID instruction load enable; 0 = stall
pcSrc  out  2  00 PC+4, 01 taken branch, 10 j, 11 jr
pc_target  out  32  next PC when pcSrc != 00
ex_ctrl  out  9  [8]reg_write [7]mem_to_reg [6]mem_read [5]mem_write [4]alu_src [3]reg_dst [2:0]alu_op
ex_rs_data  out  32  registered rs operand
ex_rt_data  out  32  registered rt operand
ex_imm  out  32  registered sign-extended immediate
ex_regs  out  15  registered {rs, rt, rd}
ex_pc  out  32  registered PC+4

Behaviour:
- Reset (async): all registers 0, all ex_* outputs 0, ex_pc = RESET_PC. Outputs are bubble-valid immediately.
- alu_op: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- Decode:
  - R-type (op 000000): add/sub/and/or/slt via funct 100000/100010/100100/100101/101010; jr = funct 001000.
  - lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, slti 001010, j 000010.
  - Any other opcode or funct gives ex_ctrl = 0 (NOP).
- Register file:
  - Write on rising edge when wb_reg_write and wb_dest != 0.
  - Reads are combinational with write-through: if wb_reg_write and wb_dest == src != 0, the read returns wb_data.
  - Index 0 always reads 0.
- Branch and jump (combinational from the current IF/ID contents):
  - beq taken if rs == rt; bne taken if rs != rt.
  - Branch target = pc_ifid + (sext(imm) << 2).
  - j target = {pc_ifid[31:28], instr[25:0], 00}; jr target = rs value.
  - pc_target = 0 when pcSrc = 00.
- Hazard stall (combinational). Stall is asserted when any of the following holds:
  - (a) Load-use: ID/EX holds a load (ex_ctrl[6]) with dest rt != 0, and that dest equals rs, or equals rt for R-type, beq, bne or sw.
  - (b) beq, bne or jr source equals the ID/EX destination (reg_dst ? rd : rt), with ex_ctrl[8] set and dest != 0.
  - (c) beq, bne or jr source equals mem_dest != 0, under the rule given in Optional Feature.
- On stall:
  - ld_pc = 0, ld_reg_instrIFID = 0, pcSrc = 00.
  - The ID/EX register captures a bubble: ex_ctrl = 0, data fields 0.
- No stall:
  - ld_pc = ld_reg_instrIFID = 1.
  - ID/EX captures the decoded bundle every cycle; latency is 1 cycle.
- When pcSrc != 00, IF/ID clears the following slot. The branch or jump instruction itself still enters ID/EX with ex_ctrl = 0.
- Stall has priority over a taken branch. Stall persists until the producer advances, with no limit on cycles.
- Reset asserted mid-stall clears everything asynchronously. The first cycle after release decodes instr_ifid normally.

Optional Feature:
- Macro ID_BRANCH_FWD_EN.
- Defined:
  - Branch and jr comparands take mem_alu_result when mem_reg_write, !mem_mem_read and mem_dest equals the source (!= 0).
  - Rule (c) stalls only when mem_mem_read.
- Undefined:
  - No forwarding from MEM.
  - Rule (c) stalls whenever mem_reg_write and mem_dest matches (!= 0).

Test Plan:
- Reset: assert rst with no clock -> all ex_* = 0, ld_pc = 1, pcSrc = 00 for instr 0; write via wb_* -> reads back; writing $0 -> $0 still reads 0.
- add $3,$1,$2 with $1 = 5, $2 = 7 -> next cycle ex_ctrl = 9'b1_0000_1_000, ex_rs_data = 5, ex_rt_data = 7, ex_regs = {1,2,3}.
- Write-through: wb write $4 = 0xABCD in the same cycle as add $5,$4,$0 decodes -> ex_rs_data = 0xABCD.
- Load-use: lw $2,0($1) in ID/EX, add $3,$2,$2 in ID -> one stall cycle (ld_pc = 0, bubble ex_ctrl = 0), then add issues.
- Branch: beq $1,$2,+3 with $1 = $2 = 9, pc_ifid = 0x100 -> pcSrc = 01, pc_target = 0x10C; bne on the same values -> pcSrc = 00.
- j 0x40 with pc_ifid = 0x1000_0004 -> pcSrc = 10, pc_target = 0x1000_0100. jr $31 with an ALU producer of $31 in MEM -> forwarded target with no stall if ID_BRANCH_FWD_EN, else one stall cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register: register file, branch/jump resolution, hazard stall.
// Optional macro ID_BRANCH_FWD_EN forwards MEM-stage ALU results into branch/jr comparands.
module id_ex_stage #(
    parameter int          RF_DEPTH = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_ifid,
    input  logic [31:0] pc_ifid,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_data,
    input  logic        mem_reg_write,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_alu_result,
    output logic        ld_pc,
    output logic        ld_reg_instrIFID,
    output logic [1:0]  pcSrc,
    output logic [31:0] pc_target,
    output logic [8:0]  ex_ctrl,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [14:0] ex_regs,
    output logic [31:0] ex_pc
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;
    localparam logic [1:0] PC_JR  = 2'b11;

    function automatic logic [8:0] mk_ctrl(input logic rw, input logic m2r, input logic mr,
                                           input logic mw, input logic asrc, input logic rdst,
                                           input logic [2:0] aop);
        return {rw, m2r, mr, mw, asrc, rdst, aop};
    endfunction

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sext;

    assign opcode   = instr_ifid[31:26];
    assign rs       = instr_ifid[25:21];
    assign rt       = instr_ifid[20:16];
    assign rd       = instr_ifid[15:11];
    assign funct    = instr_ifid[5:0];
    assign imm_sext = {{16{instr_ifid[15]}}, instr_ifid[15:0]};

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] rf_q [RF_DEPTH];
    logic [31:0] rf_d [RF_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < RF_DEPTH; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign rf_d[gi] = '0;
            end else begin : g_reg
                assign rf_d[gi] = (wb_reg_write && (wb_dest == 5'(gi))) ? wb_data : rf_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Write-through lets an instruction in ID see a value retiring in WB this same cycle.
    logic [31:0] rs_rd;
    logic [31:0] rt_rd;

    always_comb begin
        rs_rd = rf_q[rs];
        rt_rd = rf_q[rt];
        if (wb_reg_write && (wb_dest == rs)) begin
            rs_rd = wb_data;
        end
        if (wb_reg_write && (wb_dest == rt)) begin
            rt_rd = wb_data;
        end
        if (rs == 5'd0) begin
            rs_rd = '0;
        end
        if (rt == 5'd0) begin
            rt_rd = '0;
        end
    end

    // ------------------------------------------------------------------
    // Branch comparands
    // ------------------------------------------------------------------
    logic [31:0] rs_cmp;
    logic [31:0] rt_cmp;
    logic        mem_dest_rs;
    logic        mem_dest_rt;

    assign mem_dest_rs = (mem_dest != 5'd0) && (mem_dest == rs);
    assign mem_dest_rt = (mem_dest != 5'd0) && (mem_dest == rt);

`ifdef ID_BRANCH_FWD_EN
    logic mem_fwd_ok;
    assign mem_fwd_ok = mem_reg_write && !mem_mem_read;
    assign rs_cmp     = (mem_fwd_ok && mem_dest_rs) ? mem_alu_result : rs_rd;
    assign rt_cmp     = (mem_fwd_ok && mem_dest_rt) ? mem_alu_result : rt_rd;
`else
    logic unused_mem_fwd;
    assign unused_mem_fwd = ^{mem_mem_read, mem_alu_result};
    assign rs_cmp         = rs_rd;
    assign rt_cmp         = rt_rd;
`endif

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [8:0] ctrl_dec;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic       is_jr;
    logic       uses_rt;

    always_comb begin
        ctrl_dec = '0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jr    = 1'b0;
        uses_rt  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                uses_rt = 1'b1;
                case (funct)
                    FN_ADD:  ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD);
                    FN_SUB:  ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_SUB);
                    FN_AND:  ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_AND);
                    FN_OR:   ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OR);
                    FN_SLT:  ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_SLT);
                    FN_JR:   is_jr = 1'b1;
                    default: ctrl_dec = '0;
                endcase
            end
            OP_LW:   ctrl_dec = mk_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ALU_ADD);
            OP_SW: begin
                uses_rt  = 1'b1;
                ctrl_dec = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD);
            end
            OP_BEQ: begin
                uses_rt = 1'b1;
                is_beq  = 1'b1;
            end
            OP_BNE: begin
                uses_rt = 1'b1;
                is_bne  = 1'b1;
            end
            OP_ADDI: ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD);
            OP_SLTI: ctrl_dec = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_SLT);
            OP_J:    is_j = 1'b1;
            default: ctrl_dec = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic [8:0]  ex_ctrl_q;
    logic [8:0]  ex_ctrl_d;
    logic [31:0] ex_rs_data_q;
    logic [31:0] ex_rs_data_d;
    logic [31:0] ex_rt_data_q;
    logic [31:0] ex_rt_data_d;
    logic [31:0] ex_imm_q;
    logic [31:0] ex_imm_d;
    logic [14:0] ex_regs_q;
    logic [14:0] ex_regs_d;
    logic [31:0] ex_pc_q;
    logic [31:0] ex_pc_d;

    logic [4:0] ex_load_dest;
    logic [4:0] ex_wr_dest;
    logic       is_branch;
    logic       br_reads_id;
    logic       haz_load_use;
    logic       haz_ex_branch;
    logic       haz_mem_branch;
    logic       stall;

    assign ex_load_dest = ex_regs_q[9:5];
    assign ex_wr_dest   = ex_ctrl_q[3] ? ex_regs_q[4:0] : ex_regs_q[9:5];
    assign is_branch    = is_beq || is_bne;
    assign br_reads_id  = is_branch || is_jr;

    always_comb begin
        haz_load_use   = ex_ctrl_q[6] && (ex_load_dest != 5'd0) &&
                         ((ex_load_dest == rs) || (uses_rt && (ex_load_dest == rt)));
        haz_ex_branch  = br_reads_id && ex_ctrl_q[8] && (ex_wr_dest != 5'd0) &&
                         ((ex_wr_dest == rs) || (is_branch && (ex_wr_dest == rt)));
`ifdef ID_BRANCH_FWD_EN
        haz_mem_branch = br_reads_id && mem_mem_read &&
                         (mem_dest_rs || (is_branch && mem_dest_rt));
`else
        haz_mem_branch = br_reads_id && mem_reg_write &&
                         (mem_dest_rs || (is_branch && mem_dest_rt));
`endif
        stall = haz_load_use || haz_ex_branch || haz_mem_branch;
    end

    // ------------------------------------------------------------------
    // Next-PC selection; a stall suppresses any redirect
    // ------------------------------------------------------------------
    always_comb begin
        ld_pc            = !stall;
        ld_reg_instrIFID = !stall;
        pcSrc            = PC_SEQ;
        pc_target        = '0;
        if (!stall) begin
            if (is_j) begin
                pcSrc     = PC_J;
                pc_target = {pc_ifid[31:28], instr_ifid[25:0], 2'b00};
            end else if (is_jr) begin
                pcSrc     = PC_JR;
                pc_target = rs_cmp;
            end else if ((is_beq && (rs_cmp == rt_cmp)) || (is_bne && (rs_cmp != rt_cmp))) begin
                pcSrc     = PC_BR;
                pc_target = pc_ifid + {imm_sext[29:0], 2'b00};
            end
        end
    end

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    always_comb begin
        ex_ctrl_d    = '0;
        ex_rs_data_d = '0;
        ex_rt_data_d = '0;
        ex_imm_d     = '0;
        ex_regs_d    = '0;
        ex_pc_d      = '0;
        if (!stall) begin
            ex_ctrl_d    = ctrl_dec;
            ex_rs_data_d = rs_rd;
            ex_rt_data_d = rt_rd;
            ex_imm_d     = imm_sext;
            ex_regs_d    = {rs, rt, rd};
            ex_pc_d      = pc_ifid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ctrl_q    <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_regs_q    <= '0;
            ex_pc_q      <= RESET_PC;
        end else begin
            ex_ctrl_q    <= ex_ctrl_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= ex_imm_d;
            ex_regs_q    <= ex_regs_d;
            ex_pc_q      <= ex_pc_d;
        end
    end

    assign ex_ctrl    = ex_ctrl_q;
    assign ex_rs_data = ex_rs_data_q;
    assign ex_rt_data = ex_rt_data_q;
    assign ex_imm     = ex_imm_q;
    assign ex_regs    = ex_regs_q;
    assign ex_pc      = ex_pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; expected values are hand-computed from the instruction set.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_ifid;
    logic [31:0] pc_ifid;
    logic        wb_reg_write;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic [4:0]  mem_dest;
    logic [31:0] mem_alu_result;
    logic        ld_pc;
    logic        ld_reg_instrIFID;
    logic [1:0]  pcSrc;
    logic [31:0] pc_target;
    logic [8:0]  ex_ctrl;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [14:0] ex_regs;
    logic [31:0] ex_pc;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    id_ex_stage dut (
        .clk              (clk),
        .rst              (rst),
        .instr_ifid       (instr_ifid),
        .pc_ifid          (pc_ifid),
        .wb_reg_write     (wb_reg_write),
        .wb_dest          (wb_dest),
        .wb_data          (wb_data),
        .mem_reg_write    (mem_reg_write),
        .mem_mem_read     (mem_mem_read),
        .mem_dest         (mem_dest),
        .mem_alu_result   (mem_alu_result),
        .ld_pc            (ld_pc),
        .ld_reg_instrIFID (ld_reg_instrIFID),
        .pcSrc            (pcSrc),
        .pc_target        (pc_target),
        .ex_ctrl          (ex_ctrl),
        .ex_rs_data       (ex_rs_data),
        .ex_rt_data       (ex_rt_data),
        .ex_imm           (ex_imm),
        .ex_regs          (ex_regs),
        .ex_pc            (ex_pc)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s value=%h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
        instr_ifid   = 32'h0;
        wb_reg_write = 1'b1;
        wb_dest      = idx;
        wb_data      = val;
        tick();
        wb_reg_write = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        instr_ifid     = 32'h0;
        pc_ifid        = 32'h0;
        wb_reg_write   = 1'b0;
        wb_dest        = 5'd0;
        wb_data        = 32'h0;
        mem_reg_write  = 1'b0;
        mem_mem_read   = 1'b0;
        mem_dest       = 5'd0;
        mem_alu_result = 32'h0;
        #3;
        check_value("rst_ex_ctrl", 32'(ex_ctrl), 32'h0);
        check_value("rst_ex_rs", ex_rs_data, 32'h0);
        check_value("rst_ex_regs", 32'(ex_regs), 32'h0);
        check_value("rst_ex_pc", ex_pc, 32'h0);
        check_value("rst_ld_pc", 32'(ld_pc), 32'h1);
        check_value("rst_pcsrc", 32'(pcSrc), 32'h0);
        rst = 1'b0;

        write_reg(5'd1, 32'd5);
        write_reg(5'd2, 32'd7);
        write_reg(5'd0, 32'hDEAD);

        instr_ifid = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        pc_ifid    = 32'h40;
        tick();
        check_value("add_ctrl", 32'(ex_ctrl), 32'h108);
        check_value("add_rs", ex_rs_data, 32'd5);
        check_value("add_rt", ex_rt_data, 32'd7);
        check_value("add_regs", 32'(ex_regs), 32'(15'b00001_00010_00011));
        check_value("add_pc", ex_pc, 32'h40);

        instr_ifid = rtype(5'd0, 5'd1, 5'd5, 6'h20);
        tick();
        check_value("zero_reg_rs", ex_rs_data, 32'h0);
        check_value("zero_reg_rt", ex_rt_data, 32'd5);

        instr_ifid   = rtype(5'd4, 5'd0, 5'd5, 6'h20);
        wb_reg_write = 1'b1;
        wb_dest      = 5'd4;
        wb_data      = 32'hABCD;
        tick();
        wb_reg_write = 1'b0;
        check_value("wthru_rs", ex_rs_data, 32'hABCD);

        instr_ifid = rtype(5'd1, 5'd2, 5'd6, 6'h22);
        tick();
        check_value("sub_ctrl", 32'(ex_ctrl), 32'h109);

        instr_ifid = itype(6'h0A, 5'd1, 5'd7, 16'hFFFC);
        tick();
        check_value("slti_ctrl", 32'(ex_ctrl), 32'h114);
        check_value("slti_imm", ex_imm, 32'hFFFF_FFFC);

        instr_ifid = itype(6'h2B, 5'd1, 5'd2, 16'h0010);
        tick();
        check_value("sw_ctrl", 32'(ex_ctrl), 32'h030);
        check_value("sw_imm", ex_imm, 32'h10);

        instr_ifid = 32'hFC00_0000;
        tick();
        check_value("illegal_ctrl", 32'(ex_ctrl), 32'h0);

        // load-use: lw $2 then add $3,$2,$2
        instr_ifid = itype(6'h23, 5'd1, 5'd2, 16'h0000);
        tick();
        check_value("lw_ctrl", 32'(ex_ctrl), 32'h1D0);
        instr_ifid = rtype(5'd2, 5'd2, 5'd3, 6'h20);
        settle();
        check_value("lu_ld_pc", 32'(ld_pc), 32'h0);
        check_value("lu_ld_ifid", 32'(ld_reg_instrIFID), 32'h0);
        tick();
        check_value("lu_bubble_ctrl", 32'(ex_ctrl), 32'h0);
        check_value("lu_bubble_rs", ex_rs_data, 32'h0);
        check_value("lu_release", 32'(ld_pc), 32'h1);
        tick();
        check_value("lu_issue_ctrl", 32'(ex_ctrl), 32'h108);
        check_value("lu_issue_rs", ex_rs_data, 32'd7);

        write_reg(5'd1, 32'd9);
        write_reg(5'd2, 32'd9);
        instr_ifid = itype(6'h04, 5'd1, 5'd2, 16'h0003);
        pc_ifid    = 32'h100;
        settle();
        check_value("beq_pcsrc", 32'(pcSrc), 32'h1);
        check_value("beq_target", pc_target, 32'h10C);
        tick();
        check_value("beq_ctrl", 32'(ex_ctrl), 32'h0);
        instr_ifid = itype(6'h05, 5'd1, 5'd2, 16'h0003);
        settle();
        check_value("bne_pcsrc", 32'(pcSrc), 32'h0);
        check_value("bne_target", pc_target, 32'h0);

        // addi $1 in ID/EX makes the following beq wait a cycle
        instr_ifid = itype(6'h08, 5'd0, 5'd1, 16'd9);
        tick();
        instr_ifid = itype(6'h04, 5'd1, 5'd2, 16'h0003);
        settle();
        check_value("brhaz_ld_pc", 32'(ld_pc), 32'h0);
        check_value("brhaz_pcsrc", 32'(pcSrc), 32'h0);
        tick();
        check_value("brhaz_bubble", 32'(ex_ctrl), 32'h0);
        check_value("brhaz_taken", 32'(pcSrc), 32'h1);

        instr_ifid = {6'b000010, 26'h40};
        pc_ifid    = 32'h1000_0004;
        settle();
        check_value("j_pcsrc", 32'(pcSrc), 32'h2);
        check_value("j_target", pc_target, 32'h1000_0100);
        tick();

        write_reg(5'd31, 32'h2000);
        instr_ifid     = rtype(5'd31, 5'd0, 5'd0, 6'h08);
        mem_reg_write  = 1'b1;
        mem_mem_read   = 1'b0;
        mem_dest       = 5'd31;
        mem_alu_result = 32'h3000;
        settle();
`ifdef ID_BRANCH_FWD_EN
        check_value("jr_fwd_pcsrc", 32'(pcSrc), 32'h3);
        check_value("jr_fwd_target", pc_target, 32'h3000);
        check_value("jr_fwd_ld_pc", 32'(ld_pc), 32'h1);
`else
        check_value("jr_mem_ld_pc", 32'(ld_pc), 32'h0);
        check_value("jr_mem_pcsrc", 32'(pcSrc), 32'h0);
`endif
        mem_mem_read = 1'b1;
        settle();
        check_value("jr_mem_load_stall", 32'(ld_pc), 32'h0);
        mem_reg_write = 1'b0;
        mem_mem_read  = 1'b0;
        wb_reg_write  = 1'b1;
        wb_dest       = 5'd31;
        wb_data       = 32'h3000;
        settle();
        check_value("jr_wb_pcsrc", 32'(pcSrc), 32'h3);
        check_value("jr_wb_target", pc_target, 32'h3000);
        tick();
        wb_reg_write = 1'b0;

        // reset while a load-use stall is in progress
        instr_ifid = itype(6'h23, 5'd1, 5'd2, 16'h0000);
        tick();
        instr_ifid = rtype(5'd2, 5'd2, 5'd3, 6'h20);
        settle();
        check_value("rststall_ld_pc", 32'(ld_pc), 32'h0);
        rst = 1'b1;
        settle();
        check_value("rststall_ctrl", 32'(ex_ctrl), 32'h0);
        check_value("rststall_regs", 32'(ex_regs), 32'h0);
        check_value("rststall_ld_pc_after", 32'(ld_pc), 32'h1);
        #2;
        rst        = 1'b0;
        instr_ifid = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        tick();
        check_value("post_rst_ctrl", 32'(ex_ctrl), 32'h108);
        check_value("post_rst_rf_cleared", ex_rs_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
